// File: rtl/gray_counter_n.sv
// Gray-coded up/down counter with load, wrap or saturate at the terminal count,
// sticky overflow/underflow flags and a one-cycle terminal-count pulse.
// Optional macro GRAY_COUNTER_N_BIN_OUT_EN adds a BinOut port carrying the
// registered binary count.
module gray_counter_n #(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             ClrOvf,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow,
    output logic             Underflow,
`ifdef GRAY_COUNTER_N_BIN_OUT_EN
    output logic             Tc,
    output logic [WIDTH-1:0] BinOut
`else
    output logic             Tc
`endif
);

    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] Zero    = '0;
    localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             tc_q, tc_d;
    logic             term_up, term_dn;

    // Terminal events only exist for an enabled count step; Load suppresses them.
    assign term_up = ~Load & En & Up & (bin_q == AllOnes);
    assign term_dn = ~Load & En & ~Up & (bin_q == Zero);

    // Next-state selection: Load beats En; saturation holds B on a terminal event.
    always_comb begin
        bin_d = bin_q;
        if (Load) begin
            bin_d = LoadValue;
        end else if (En) begin
            if ((term_up | term_dn) && SATURATE) begin
                bin_d = bin_q;
            end else if (Up) begin
                bin_d = bin_q + One;
            end else begin
                bin_d = bin_q - One;
            end
        end
        // Gray value is derived from next-state B so Output stays a pure register.
        gray_d = bin_d ^ (bin_d >> 1);
        tc_d   = term_up | term_dn;
        // A terminal event on the same edge outranks the clear.
        ovf_d = term_up ? 1'b1 : (ClrOvf ? 1'b0 : ovf_q);
        unf_d = term_dn ? 1'b1 : (ClrOvf ? 1'b0 : unf_q);
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            tc_q   <= tc_d;
        end
    end

    assign Output    = gray_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Tc        = tc_q;
`ifdef GRAY_COUNTER_N_BIN_OUT_EN
    assign BinOut    = bin_q;
`endif

endmodule
